// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon sequence memory.
//   colour_t    : colour code on the generator, guess and playback buses (0 = none)
//   seq_state_t : sequence memory controller states
//   COLOUR_W    : width of a colour code
package simon_pkg;

    localparam int unsigned COLOUR_W = 3;

    typedef enum logic [COLOUR_W-1:0] {
        NONE   = 3'd0,
        GREEN  = 3'd1,
        RED    = 3'd2,
        YELLOW = 3'd3,
        BLUE   = 3'd4
    } colour_t;

    typedef enum logic [2:0] {
        StIdle,
        StRequest,
        StWaitGen,
        StPlayOn,
        StPlayGap
    } seq_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Only 1..4 are real colours.
    function automatic logic colour_valid(input logic [COLOUR_W-1:0] c);
        return (c != '0) && (c <= COLOUR_W'(4));
    endfunction

    // Colours 1..4 are stored as 0..3; BLUE (3'b100) wraps to 2'b11.
    function automatic logic [1:0] colour_to_entry(input logic [COLOUR_W-1:0] c);
        return c[1:0] - 2'd1;
    endfunction

    function automatic logic [COLOUR_W-1:0] entry_to_colour(input logic [1:0] e);
        return {1'b0, e} + COLOUR_W'(1);
    endfunction

endpackage

// File: rtl/pace_timer.sv
// Loadable down-counter used for playback ON/GAP timing and the generator timeout.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_load         : load i_value into the counter
//   i_value        : number of cycles to count (>= 1)
//   o_done         : high during the last counted cycle after a load
module pace_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [Width-1:0] i_value,
    output logic             o_done
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_value;
        end else if (count_q != '0) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A load of N leaves the counter at N in the first cycle, so the count of 1 marks cycle N.
    assign o_done = (count_q == Width'(1));

endmodule

// File: rtl/sequence_memory_module.sv
// Simon colour sequence memory: requests values from the random generator, stores the
// sequence, plays it back as timed colour pulses and checks player guesses.
// Optional feature macro: GEN_TIMEOUT_EN (abandon a generator wait after TIMEOUT_CYCLES).
//   i_clk, i_rst_n       : clock, synchronous active-low reset
//   i_clear              : empty the sequence and return to idle
//   i_extend             : request and append one generator value
//   i_play               : play back the whole sequence
//   i_guess_valid/value  : player guess strobe and colour
//   i_gen_ready/value    : generator response
//   o_gen_request        : one-cycle trigger to the generator
//   o_play_valid/value   : colour currently shown (value 0 when not shown)
//   o_match/o_mismatch   : guess result pulses
//   o_round_done         : whole sequence guessed correctly
//   o_length, o_full     : sequence length and full flag
//   o_busy               : not idle
//   o_gen_error          : bad generator value or timeout
module sequence_memory_module
    import simon_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 32,
    parameter int unsigned ON_CYCLES      = 50_000_000,
    parameter int unsigned GAP_CYCLES     = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clear,
    input  logic                         i_extend,
    input  logic                         i_play,
    input  logic                         i_guess_valid,
    input  logic [COLOUR_W-1:0]          i_guess_value,
    input  logic                         i_gen_ready,
    input  logic [COLOUR_W-1:0]          i_gen_value,
    output logic                         o_gen_request,
    output logic                         o_play_valid,
    output logic [COLOUR_W-1:0]          o_play_value,
    output logic                         o_match,
    output logic                         o_mismatch,
    output logic                         o_round_done,
    output logic [$clog2(MAX_LEN+1)-1:0] o_length,
    output logic                         o_full,
    output logic                         o_busy,
    output logic                         o_gen_error
);

    localparam int unsigned LenW      = $clog2(MAX_LEN + 1);
    localparam int unsigned IdxW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned MaxCycles = max_u(ON_CYCLES, max_u(GAP_CYCLES, TIMEOUT_CYCLES));
    localparam int unsigned TimerW    = $clog2(MaxCycles + 1);

    seq_state_t state_q, state_d;
    logic [LenW-1:0] length_q, length_d;
    logic [IdxW-1:0] gidx_q, gidx_d;
    logic [IdxW-1:0] pidx_q, pidx_d;
    logic            match_q, match_d;
    logic            mismatch_q, mismatch_d;
    logic            round_done_q, round_done_d;
    logic            gen_error_q, gen_error_d;

    logic [1:0]        mem_q [MAX_LEN];
    logic              mem_we;
    logic [IdxW-1:0]   last_idx;
    logic              full;
    logic              timer_load;
    logic [TimerW-1:0] timer_value;
    logic              timer_done;
    colour_t           play_colour;

    assign full     = (length_q == LenW'(MAX_LEN));
    assign last_idx = IdxW'(length_q - LenW'(1));

    pace_timer #(
        .Width (TimerW)
    ) u_pace_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (timer_load),
        .i_value (timer_value),
        .o_done  (timer_done)
    );

    always_comb begin
        state_d      = state_q;
        length_d     = length_q;
        gidx_d       = gidx_q;
        pidx_d       = pidx_q;
        match_d      = 1'b0;
        mismatch_d   = 1'b0;
        round_done_d = 1'b0;
        gen_error_d  = 1'b0;
        mem_we       = 1'b0;
        timer_load   = 1'b0;
        timer_value  = '0;

        if (i_clear) begin
            state_d  = StIdle;
            length_d = '0;
            gidx_d   = '0;
            pidx_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_extend && !full) begin
                        state_d = StRequest;
                        gidx_d  = '0;
                    end else if (i_play && (length_q != '0)) begin
                        state_d     = StPlayOn;
                        pidx_d      = '0;
                        gidx_d      = '0;
                        timer_load  = 1'b1;
                        timer_value = TimerW'(ON_CYCLES);
                    end else if (i_guess_valid) begin
                        if (length_q == '0) begin
                            mismatch_d = 1'b1;
                        end else if (i_guess_value == entry_to_colour(mem_q[gidx_q])) begin
                            match_d = 1'b1;
                            if (gidx_q == last_idx) begin
                                round_done_d = 1'b1;
                                gidx_d       = '0;
                            end else begin
                                gidx_d = gidx_q + IdxW'(1);
                            end
                        end else begin
                            mismatch_d = 1'b1;
                            gidx_d     = '0;
                        end
                    end
                end
                StRequest: begin
                    state_d = StWaitGen;
`ifdef GEN_TIMEOUT_EN
                    timer_load  = 1'b1;
                    timer_value = TimerW'(TIMEOUT_CYCLES);
`endif
                end
                StWaitGen: begin
                    if (i_gen_ready) begin
                        state_d = StIdle;
                        if (colour_valid(i_gen_value)) begin
                            mem_we   = 1'b1;
                            length_d = length_q + LenW'(1);
                        end else begin
                            gen_error_d = 1'b1;
                        end
`ifdef GEN_TIMEOUT_EN
                    end else if (timer_done) begin
                        state_d     = StIdle;
                        gen_error_d = 1'b1;
`endif
                    end
                end
                StPlayOn: begin
                    if (timer_done) begin
                        state_d     = StPlayGap;
                        timer_load  = 1'b1;
                        timer_value = TimerW'(GAP_CYCLES);
                    end
                end
                StPlayGap: begin
                    if (timer_done) begin
                        if (pidx_q == last_idx) begin
                            state_d = StIdle;
                        end else begin
                            state_d     = StPlayOn;
                            pidx_d      = pidx_q + IdxW'(1);
                            timer_load  = 1'b1;
                            timer_value = TimerW'(ON_CYCLES);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            length_q     <= '0;
            gidx_q       <= '0;
            pidx_q       <= '0;
            match_q      <= 1'b0;
            mismatch_q   <= 1'b0;
            round_done_q <= 1'b0;
            gen_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            length_q     <= length_d;
            gidx_q       <= gidx_d;
            pidx_q       <= pidx_d;
            match_q      <= match_d;
            mismatch_q   <= mismatch_d;
            round_done_q <= round_done_d;
            gen_error_q  <= gen_error_d;
        end
    end

    // Storage needs no reset: entries at or beyond length are never read.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[IdxW'(length_q)] <= colour_to_entry(i_gen_value);
        end
    end

    always_comb begin
        play_colour = NONE;
        if (state_q == StPlayOn) begin
            play_colour = colour_t'(entry_to_colour(mem_q[pidx_q]));
        end
    end

    assign o_gen_request = (state_q == StRequest);
    assign o_play_valid  = (state_q == StPlayOn);
    assign o_play_value  = play_colour;
    assign o_match       = match_q;
    assign o_mismatch    = mismatch_q;
    assign o_round_done  = round_done_q;
    assign o_length      = length_q;
    assign o_full        = full;
    assign o_busy        = (state_q != StIdle);
    assign o_gen_error   = gen_error_q;

endmodule
